// File: rtl/prog_loader.sv
// UART program loader: receives framed words into a 256x16 program
// memory and holds the CPU in reset while loading. Optional macro: LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int CLK_DIV     = 234,
  parameter int TIMEOUT_CYC = 2700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [10:0] adr,
  output logic [15:0] dout,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]    SYNC      = 8'hA5;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } ustate_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DLO,
    DHI,
    CSUM
  } state_t;

  logic          rx_s1_q;
  logic          rx_s2_q;
  logic          rx_s3_q;

  ustate_t       us_q;
  ustate_t       us_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    sh_q;
  logic [7:0]    sh_d;
  logic          byte_valid;
  logic          frame_err;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    n_q;
  logic [7:0]    n_d;
  logic [7:0]    wptr_q;
  logic [7:0]    wptr_d;
  logic [7:0]    lo_q;
  logic [7:0]    lo_d;
  logic [7:0]    sum_q;
  logic [7:0]    sum_d;
  logic          done_q;
  logic          done_d;
  logic          err_q;
  logic          err_d;
  logic          cpu_rst_n_q;
  logic          cpu_rst_n_d;

  logic          we;
  logic [15:0]   wdata;
  logic [8:0]    words_done;
  logic [8:0]    words_tgt;
  logic          tmo;

  logic [15:0]   mem [256];

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // UART receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      us_q  <= U_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      us_q  <= us_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  // UART receiver: mid-bit sampling, LSB first, stop bit check
  always_comb begin
    us_d       = us_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (us_q)
      U_IDLE: begin
        cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) begin
          us_d = U_START;
        end
      end
      U_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          us_d  = rx_s2_q ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            us_d = U_STOP;
          end
        end
      end
      U_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          us_d  = U_IDLE;
          if (rx_s2_q) begin
            byte_valid = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: us_d = U_IDLE;
    endcase
  end

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] gap_q;

  // Byte-gap counter: restarts on every byte, idle outside a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q <= '0;
    end else if (byte_valid || !busy) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 32'd1;
    end
  end

  assign tmo = busy && (gap_q == 32'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // N=0 encodes 256 words; compare against count after this write
  assign words_done = {1'b0, wptr_q} + 9'd1;
  assign words_tgt  = (n_q == 8'd0) ? 9'd256 : {1'b0, n_q};

  // Loader FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      wptr_q      <= '0;
      lo_q        <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wptr_q      <= wptr_d;
      lo_q        <= lo_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // Loader FSM: frame parsing, write strobe and status flags
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    wptr_d      = wptr_q;
    lo_d        = lo_q;
    sum_d       = sum_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    we          = 1'b0;
    wdata       = {sh_q, lo_q};
    if (byte_valid) begin
      unique case (state_q)
        IDLE: begin
          if (sh_q == SYNC) begin
            state_d     = LEN;
            done_d      = 1'b0;
            err_d       = 1'b0;
            cpu_rst_n_d = 1'b0;
          end
        end
        LEN: begin
          n_d     = sh_q;
          wptr_d  = '0;
          sum_d   = '0;
          state_d = DLO;
        end
        DLO: begin
          lo_d    = sh_q;
          sum_d   = sum_q + sh_q;
          state_d = DHI;
        end
        DHI: begin
          we      = 1'b1;
          sum_d   = sum_q + sh_q;
          wptr_d  = wptr_q + 8'd1;
          state_d = (words_done == words_tgt) ? CSUM : DLO;
        end
        CSUM: begin
          state_d = IDLE;
          if (sh_q == sum_q) begin
            done_d      = 1'b1;
            err_d       = 1'b0;
            cpu_rst_n_d = 1'b1;
          end else begin
            done_d = 1'b0;
            err_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((frame_err || tmo) && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  // Program memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr_q] <= wdata;
    end
  end

  assign dout        = (adr[10:8] == 3'd0) ? mem[adr[7:0]] : 16'h0000;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign cpu_reset_n = cpu_rst_n_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: serial frames in, frame outcome
// and memory image checked against a frame-level reference model.
module tb_prog_loader;

  localparam int CLK_DIV = 8;
  localparam int TMO     = 1000;

  typedef struct packed {
    logic done;
    logic err;
    logic cpu;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [10:0] adr;
  logic [15:0] dout;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        busy_prev = 1'b0;
  logic [15:0] mem_m [256];
  bit          known [256];
  logic [15:0] wbuf  [256];

  always #5 clk = ~clk;

  prog_loader #(
    .CLK_DIV    (CLK_DIV),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .adr        (adr),
    .dout       (dout),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: frame start clears flags; frame end pops an expectation
  always @(negedge clk) begin
    if (busy === 1'b1 && !busy_prev) begin
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_cpu", cpu_reset_n, 0);
    end
    if (busy === 1'b0 && busy_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_end: got unexpected end, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("end_done", done, mon_e.done);
        chk("end_err", err, mon_e.err);
        chk("end_cpu", cpu_reset_n, mon_e.cpu);
      end
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  // Reference model: derive outcome and memory image from the frame
  task automatic send_frame(input int n, input int csum_ovr,
                            input int fe_idx);
    logic [7:0] bytes[$];
    logic [7:0] s;
    logic [7:0] cs;
    int         nw;
    exp_t       e;
    s = 8'd0;
    bytes.push_back(8'hA5);
    bytes.push_back(8'(n));
    for (int w = 0; w < n; w++) begin
      bytes.push_back(wbuf[w][7:0]);
      bytes.push_back(wbuf[w][15:8]);
      s = s + wbuf[w][7:0] + wbuf[w][15:8];
    end
    cs = (csum_ovr < 0) ? s : 8'(csum_ovr);
    bytes.push_back(cs);
    if (fe_idx >= 0) begin
      nw = (fe_idx < 2) ? 0 : (fe_idx - 2) / 2;
      if (nw > n) nw = n;
      e = '{1'b0, 1'b1, 1'b0};
    end else begin
      nw = n;
      e = (cs == s) ? '{1'b1, 1'b0, 1'b1} : '{1'b0, 1'b1, 1'b0};
    end
    for (int w = 0; w < nw; w++) begin
      mem_m[w] = wbuf[w];
      known[w] = 1'b1;
    end
    exp_q.push_back(e);
    for (int i = 0; i < bytes.size(); i++) begin
      if (fe_idx >= 0 && i > fe_idx) break;
      send_byte(bytes[i], i != fe_idx);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_mem();
    for (int i = 0; i < 256; i++) begin
      if (known[i]) begin
        adr = 11'(i);
        #1;
        chk($sformatf("mem[%0d]", i), dout, mem_m[i]);
      end
    end
  endtask

  task automatic noise();
    logic [7:0] b;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, 1'b1);
    end
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int         n;
    rx    = 1'b1;
    adr   = '0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cpu", cpu_reset_n, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    send_frame(2, -1, -1);
    drain();
    adr = 11'd1;
    #1 chk("dout_a1", dout, 16'hABCD);
    adr = 11'd0;
    #1 chk("dout_a0", dout, 16'h1234);

    send_frame(2, 0, -1);
    drain();
    check_mem();

    wbuf[0] = 16'hA5A5;
    wbuf[1] = 16'h00A5;
    wbuf[2] = 16'hA500;
    send_frame(3, -1, -1);
    drain();
    check_mem();

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    for (int i = 0; i < 256; i++) wbuf[i] = 16'h0101;
    send_frame(256, -1, -1);
    drain();
    check_mem();
    adr = 11'h100;
    #1 chk("dout_hi100", dout, 16'h0000);
    adr = 11'h7FF;
    #1 chk("dout_hi7ff", dout, 16'h0000);

    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
    send_frame(4, -1, 4);
    drain();
    chk("fe_busy", busy, 0);
    wbuf[0] = 16'h5AC3;
    wbuf[1] = 16'h0F1E;
    send_frame(2, -1, -1);
    drain();
    check_mem();

    for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
    exp_q.push_back('{1'b0, 1'b0, 1'b0});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(wbuf[0][7:0], 1'b1);
    send_byte(wbuf[0][15:8], 1'b1);
    send_byte(wbuf[1][7:0], 1'b1);
    mem_m[0] = wbuf[0];
    known[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cpu", cpu_reset_n, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    drain();
    check_mem();
    repeat (20) @(negedge clk);
    chk("rstmid_cpu_hold", cpu_reset_n, 0);

    for (int k = 0; k < 4; k++) begin
      noise();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_frame(n, -1, $urandom_range(1, 2 + 2 * n));
      end else if ($urandom_range(0, 3) == 0) begin
        s = 8'd0;
        for (int i = 0; i < n; i++) s = s + wbuf[i][7:0] + wbuf[i][15:8];
        send_frame(n, int'(s + 8'd1), -1);
      end else begin
        send_frame(n, -1, -1);
      end
      drain();
    end
    check_mem();

    wbuf[0] = 16'h7711;
    wbuf[1] = 16'h2288;
`ifdef LOADER_TIMEOUT_EN
    exp_q.push_back('{1'b0, 1'b1, 1'b0});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (TMO + 200) @(negedge clk);
    drain();
    chk("tmo_busy", busy, 0);
`else
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (TMO + 500) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_cpu", cpu_reset_n, 0);
    exp_q.push_back('{1'b1, 1'b0, 1'b1});
    mem_m[0] = wbuf[0];
    mem_m[1] = wbuf[1];
    known[0] = 1'b1;
    known[1] = 1'b1;
    send_byte(8'h11, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h32, 1'b1);
    drain();
`endif
    check_mem();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 234, meaning clk cycles per UART bit (27 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2700000, meaning the idle-byte limit mid-frame, in clk cycles (100 ms).
REQ-003 reset: asynchronous, active-low; clock clk.
REQ-004 SHALL have port: clk  input  1  system clock, all logic on posedge.
REQ-005 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: rx  input  1  UART serial in, 8N1, idle high, asynchronous to clk.
REQ-007 SHALL have port: adr  input  11  CPU instruction fetch address.
REQ-008 SHALL have port: dout  output  16  instruction word at adr.
REQ-009 SHALL have port: cpu_reset_n  output  1  active-low hold for the CPU core.
REQ-010 SHALL have port: busy  output  1  frame in progress.
REQ-011 SHALL have port: done  output  1  last frame loaded with a good checksum.
REQ-012 SHALL have port: err  output  1  last frame aborted.

Function
REQ-013 SHALL hold a 256 x 16 program memory.
REQ-014 SHALL read memory combinationally: dout = mem[adr[7:0]] when adr[10:8]==0, else 16'h0000.
- Zero read latency, matching the CPU's same-cycle use of dout.
REQ-015 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-016 UART RX SHALL behave as follows:
- Detect a synchronized falling edge.
- Re-check the start bit at CLK_DIV/2; if high, discard and return to idle.
- Sample 8 data bits LSB-first, each CLK_DIV cycles apart.
- Sample the stop bit; stop==0 is a framing error.
REQ-017 SHALL pulse byte_valid internally for exactly 1 cycle per good byte.
REQ-018 Frame format SHALL be: 0xA5 sync, N (word count, 0 means 256), 2N data bytes (low byte first per word), checksum.
- Checksum = 8-bit wrapping sum of all 2N data bytes.
REQ-019 FSM states SHALL be: IDLE, LEN, DLO, DHI, CSUM.
REQ-020 IDLE SHALL go to LEN on byte 0xA5; any other byte is ignored.
REQ-021 LEN SHALL latch N, clear the write pointer wptr (8-bit) and clear the running sum, then go to DLO.
REQ-022 DLO SHALL latch the low byte and go to DHI.
REQ-023 DHI SHALL behave as follows:
- Write mem[wptr] <= {hi, lo} in the cycle byte_valid is seen.
- wptr increments, wrapping from 255 to 0.
- If the words written equal N (N=0 counts as 256), go to CSUM; else go to DLO.
REQ-024 CSUM SHALL behave as follows:
- On match: done=1, err=0, go to IDLE.
- On mismatch: err=1, done=0, go to IDLE.
- Memory keeps the written words in both cases.
REQ-025 cpu_reset_n SHALL be registered.
- It drives 0 from the cycle after the sync byte is accepted until the frame ends.
- It drives 1 from the cycle after a good checksum.
- It stays 0 after any error.
REQ-026 busy SHALL be 1 in LEN, DLO, DHI and CSUM, and 0 in IDLE.
REQ-027 Accepting a sync byte SHALL clear done and err in the same cycle that busy rises.
REQ-028 A framing error in any non-IDLE state SHALL set err=1, clear done and return the FSM to IDLE.
- The same framing error in IDLE is ignored.
REQ-029 A 0xA5 byte received in DLO, DHI or CSUM SHALL be treated as data, not as a resync.
REQ-030 A byte arriving in the same cycle the FSM returns to IDLE SHALL be handled by IDLE rules on the next byte_valid only; no byte is lost or double-counted.

Reset
REQ-031 reset low SHALL asynchronously force the following:
- FSM to IDLE and the UART to idle.
- wptr=0 and sum=0.
- busy=0, done=0, err=0.
- cpu_reset_n=0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
- cpu_reset_n stays 0 until a good frame is loaded after reset.
REQ-033 reset asserted mid-frame SHALL abandon the frame; any words already written are retained.

Configuration
REQ-034 Macro LOADER_TIMEOUT_EN, when defined, SHALL add a byte-gap counter.
- It is cleared on each byte_valid and counts while busy.
- At TIMEOUT_CYC it sets err=1, clears done and returns the FSM to IDLE, with cpu_reset_n held 0.
REQ-035 Without LOADER_TIMEOUT_EN there SHALL be no counter; a stalled frame waits indefinitely with busy=1.

Verification
REQ-036 Good frame A5 02 34 12 CD AB BE -> mem[0]=1234, mem[1]=ABCD, done=1, err=0, cpu_reset_n=1; adr=1 gives dout=ABCD with no latency.
REQ-037 Same frame with checksum 00 -> err=1, done=0, cpu_reset_n=0, mem[0]=1234.
REQ-038 Bytes 00 FF then good frame with N=00 and 512 bytes of value 01 (checksum 00) -> all 256 words=0101, done=1, wptr wraps to 0; adr=0x100 gives dout=0000.
REQ-039 Stop bit forced low on the 3rd data byte -> err=1, FSM IDLE; the next good frame loads and sets done=1.
REQ-040 reset pulsed low mid-frame -> busy=0 and cpu_reset_n=0 immediately, earlier words retained; with LOADER_TIMEOUT_EN and TIMEOUT_CYC=1000, a 1000-cycle gap after LEN -> err=1.
